demux_o4_x1_buf: RTL

- Buffered 1-to-4 demultiplexer. It is the distribution counterpart of the 4:1 datapath mux.
- One input stream with valid/ready handshake and a 2-bit destination select.
- Each accepted word is steered into one of four per-lane FIFOs, and each lane drains independently through its own valid/ready handshake.
- Sits between a single producer (e.g. writeback/result bus) and four consumers (register-file bank, memory port, CP0, debug tap) that can stall independently.

---
 rtl/demux_o4_x1_buf_pkg.sv | 24 ++
 rtl/demux_o4_x1_buf_lane_fifo.sv | 86 ++++++++
 rtl/demux_o4_x1_buf.sv | 82 ++++++++
 3 files changed

// File: rtl/demux_o4_x1_buf_pkg.sv
// Shared constants for the buffered 1-to-4 demultiplexer: lane select codes,
// default word width and a select-to-one-hot decode helper.
package demux_o4_x1_buf_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [1:0] LANE_RF  = 2'b00;
  localparam logic [1:0] LANE_MEM = 2'b01;
  localparam logic [1:0] LANE_CP0 = 2'b10;
  localparam logic [1:0] LANE_DBG = 2'b11;

  function automatic logic [3:0] lane_onehot(input logic [1:0] sel);
    logic [3:0] onehot;
    case (sel)
      LANE_RF:  onehot = 4'b0001;
      LANE_MEM: onehot = 4'b0010;
      LANE_CP0: onehot = 4'b0100;
      LANE_DBG: onehot = 4'b1000;
      default:  onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/demux_o4_x1_buf_lane_fifo.sv
// One lane of the demultiplexer: a first-word-fall-through FIFO whose head word
// is driven from registered storage and forced to zero while the lane is empty.
module demux_lane_fifo
  import demux_o4_x1_buf_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  DEPTH      = 2,
  localparam int CNT_W      = $clog2(DEPTH + 1),
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_full,
  output logic [CNT_W-1:0]      o_count
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  valid_s;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;

  // Occupancy flags and guarded push/pop strobes (no overflow, no underflow).
  always_comb begin
    valid_s = (count_r != {CNT_W{1'b0}});
    full_s  = (count_r == CNT_W'(DEPTH));
    push_s  = i_push && !full_s;
    pop_s   = i_pop && valid_s;
  end

  // Storage needs no reset: the empty flag masks whatever it holds.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Occupancy counter; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head word, zero while the lane is empty so outputs never carry stale data.
  always_comb begin
    if (valid_s) begin
      o_data = mem_r[rd_ptr_r];
    end else begin
      o_data = {DATA_WIDTH{1'b0}};
    end
    o_valid = valid_s;
    o_full  = full_s;
    o_count = count_r;
  end

endmodule

// File: rtl/demux_o4_x1_buf.sv
// Buffered 1-to-4 demultiplexer: steers each accepted word into one of four
// independently drained lane FIFOs selected by i_control.
module demux_o4_x1_buf
  import demux_o4_x1_buf_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  DEPTH      = 2,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_control,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data0,
  output logic [DATA_WIDTH-1:0] o_data1,
  output logic [DATA_WIDTH-1:0] o_data2,
  output logic [DATA_WIDTH-1:0] o_data3,
  output logic [3:0]            o_valid,
  input  logic [3:0]            i_ready,
  output logic [CNT_W-1:0]      o_count0,
  output logic [CNT_W-1:0]      o_count1,
  output logic [CNT_W-1:0]      o_count2,
  output logic [CNT_W-1:0]      o_count3
);

  logic [DATA_WIDTH-1:0] lane_data_s  [4];
  logic [CNT_W-1:0]      lane_count_s [4];
  logic [3:0]            lane_valid_s;
  logic [3:0]            lane_full_s;
  logic [3:0]            push_sel_s;
  logic [3:0]            pop_sel_s;

  // A full lane stays not-ready even if it drains this cycle (no pass-through).
  always_comb begin
    case (i_control)
      LANE_RF:  o_ready = !lane_full_s[0];
      LANE_MEM: o_ready = !lane_full_s[1];
      LANE_CP0: o_ready = !lane_full_s[2];
      LANE_DBG: o_ready = !lane_full_s[3];
      default:  o_ready = 1'b0;
    endcase
  end

  // Select decode for the push and consumer-side pop gating.
  always_comb begin
    push_sel_s = lane_onehot(i_control) & {4{i_valid && o_ready}};
    pop_sel_s  = i_ready & lane_valid_s;
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    demux_lane_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push_sel_s[k]),
      .i_data  (i_data),
      .i_pop   (pop_sel_s[k]),
      .o_data  (lane_data_s[k]),
      .o_valid (lane_valid_s[k]),
      .o_full  (lane_full_s[k]),
      .o_count (lane_count_s[k])
    );
  end

  // Flatten the per-lane results onto the named output ports.
  always_comb begin
    o_valid  = lane_valid_s;
    o_data0  = lane_data_s[0];
    o_data1  = lane_data_s[1];
    o_data2  = lane_data_s[2];
    o_data3  = lane_data_s[3];
    o_count0 = lane_count_s[0];
    o_count1 = lane_count_s[1];
    o_count2 = lane_count_s[2];
    o_count3 = lane_count_s[3];
  end

endmodule
